// File: rtl/rob_pr_free_q_pkg.sv
// Shared types for the ROB -> free_list PR-return path: PR encoding, bank split and queue sizing.
package rob_pr_free_q_pkg;

  localparam int ROB_FREE_WIDTH        = 4;
  localparam int ROB_PR_FREE_Q_ENTRIES = 2;
  localparam int FREE_LIST_BANK_COUNT  = 4;
  localparam int PR_WIDTH              = 7;
  localparam int BANK_BITS             = $clog2(FREE_LIST_BANK_COUNT);
  localparam int UPPER_PR_WIDTH        = PR_WIDTH - BANK_BITS;

  typedef logic [PR_WIDTH-1:0]       PR_t;
  typedef logic [UPPER_PR_WIDTH-1:0] upper_PR_t;
  typedef logic [BANK_BITS-1:0]      bank_t;

  // Bank lives in the low PR bits so consecutive PRs spread across banks.
  function automatic bank_t PR_bank_bits(input PR_t pr);
    return pr[BANK_BITS-1:0];
  endfunction

  function automatic upper_PR_t upper_PR_bits(input PR_t pr);
    return pr[PR_WIDTH-1:BANK_BITS];
  endfunction

endpackage

// File: rtl/rob_pr_free_q_if.sv
// Commit-group enqueue bus plus per-bank free_list return bus; master = ROB/free_list side, slave = queue.
interface rob_pr_free_q_if
  import rob_pr_free_q_pkg::*;
#(
  parameter int ENTRIES    = ROB_PR_FREE_Q_ENTRIES,
  parameter int FREE_WIDTH = ROB_FREE_WIDTH,
  parameter int BANK_COUNT = FREE_LIST_BANK_COUNT
);

  logic                                  enq_valid;
  logic [FREE_WIDTH-1:0]                 enq_free_mask;
  PR_t [FREE_WIDTH-1:0]                  enq_PR_by_lane;
  logic                                  enq_ready;
  logic [BANK_COUNT-1:0]                 free_valid_by_bank;
  upper_PR_t [BANK_COUNT-1:0]            free_upper_PR_by_bank;
  logic [BANK_COUNT-1:0]                 free_ready_by_bank;
  logic [$clog2(ENTRIES):0]              occupancy;

  modport master (
    output enq_valid, enq_free_mask, enq_PR_by_lane, free_ready_by_bank,
    input  enq_ready, free_valid_by_bank, free_upper_PR_by_bank, occupancy
  );

  modport slave (
    input  enq_valid, enq_free_mask, enq_PR_by_lane, free_ready_by_bank,
    output enq_ready, free_valid_by_bank, free_upper_PR_by_bank, occupancy
  );

endinterface

// File: rtl/rob_pr_free_q_bank_select.sv
// Per-bank arbiter over the head group's lanes: one-hot grant to the lowest pending lane in this bank.
// Purely combinational; holds its grant as long as the pending mask is unchanged.
module pr_free_bank_select #(
  parameter int FREE_WIDTH = 4
) (
  input  logic [FREE_WIDTH-1:0] pending_i,
  input  logic [FREE_WIDTH-1:0] bank_match_i,
  output logic [FREE_WIDTH-1:0] grant_o,
  output logic                  valid_o
);

  logic [FREE_WIDTH-1:0] req;

  assign req     = pending_i & bank_match_i;
  // Two's-complement trick isolates the lowest set bit.
  assign grant_o = req & (~req + FREE_WIDTH'(1));
  assign valid_o = |req;

endmodule

// File: rtl/rob_pr_free_q.sv
// Buffers committed PR frees and returns them to the banked free_list, one PR per bank per cycle.
// Group accepted at t is offered at t+1 earliest; enq_ready depends only on registered fullness.
module rob_pr_free_q
  import rob_pr_free_q_pkg::*;
#(
  parameter int PR_FREE_Q_ENTRIES = ROB_PR_FREE_Q_ENTRIES,
  parameter int FREE_WIDTH        = ROB_FREE_WIDTH,
  parameter int BANK_COUNT        = FREE_LIST_BANK_COUNT
) (
  input  logic            CLK,
  input  logic            nRST,
  rob_pr_free_q_if.slave  bus
);

  localparam int IDX_W = $clog2(PR_FREE_Q_ENTRIES);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PR_FREE_Q_ENTRIES-1:0][FREE_WIDTH-1:0] pending_q, pending_d;
  PR_t [PR_FREE_Q_ENTRIES-1:0][FREE_WIDTH-1:0]  pr_q;

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             empty, full, pop, enq_fire;
  logic [FREE_WIDTH-1:0] head_pending, clear;
  PR_t [FREE_WIDTH-1:0]  head_pr;

  logic [BANK_COUNT-1:0][FREE_WIDTH-1:0] bank_match, grant;
  logic [BANK_COUNT-1:0]                 bank_vld;
  upper_PR_t [BANK_COUNT-1:0]            bank_upper;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  assign head_pending = empty ? '0 : pending_q[head_idx];
  assign head_pr      = pr_q[head_idx];

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    for (genvar l = 0; l < FREE_WIDTH; l++) begin : g_lane
      assign bank_match[b][l] = (PR_bank_bits(head_pr[l]) == bank_t'(b));
    end

    pr_free_bank_select #(
      .FREE_WIDTH (FREE_WIDTH)
    ) u_sel (
      .pending_i    (head_pending),
      .bank_match_i (bank_match[b]),
      .grant_o      (grant[b]),
      .valid_o      (bank_vld[b])
    );
  end

  always_comb begin
    clear      = '0;
    bank_upper = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      for (int l = 0; l < FREE_WIDTH; l++) begin
        if (grant[b][l]) bank_upper[b] = upper_PR_bits(head_pr[l]);
      end
      if (bank_vld[b] && bus.free_ready_by_bank[b]) clear = clear | grant[b];
    end
  end

  assign bus.free_valid_by_bank    = bank_vld;
  assign bus.free_upper_PR_by_bank = bank_upper;
  assign bus.enq_ready             = !full;
  assign bus.occupancy             = tail_q - head_q;

  // An all-zero group is consumed without taking a slot.
  assign enq_fire = bus.enq_valid && !full && (|bus.enq_free_mask);
  assign pop      = !empty && ((head_pending & ~clear) == '0);

  always_comb begin
    pending_d = pending_q;
    if (!empty) pending_d[head_idx] = head_pending & ~clear;
    if (enq_fire) pending_d[tail_idx] = bus.enq_free_mask;
    head_d = head_q + PTR_W'(pop);
    tail_d = tail_q + PTR_W'(enq_fire);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q    <= '0;
      tail_q    <= '0;
      pending_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      pending_q <= pending_d;
    end
  end

  // PR payload is only observed through pending bits, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (enq_fire) pr_q[tail_idx] <= bus.enq_PR_by_lane;
  end

endmodule

// File: tb/tb_rob_pr_free_q.sv
// Directed bench for rob_pr_free_q: collision serialization, backpressure, zero groups and async reset.
module tb_rob_pr_free_q;
  import rob_pr_free_q_pkg::*;

  logic clk;
  logic nrst;
  int   n_assert;
  int   n_fail;

  rob_pr_free_q_if bus ();

  rob_pr_free_q dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] up4(input upper_PR_t u3, input upper_PR_t u2,
                                      input upper_PR_t u1, input upper_PR_t u0);
    return {u3, u2, u1, u0};
  endfunction

  task automatic check_state(input string tag, input logic exp_rdy, input logic [3:0] exp_vld,
                             input logic [19:0] exp_up, input logic [1:0] exp_occ);
    logic [19:0] obs_up;
    obs_up = bus.free_upper_PR_by_bank;
    n_assert++;
    assert (bus.enq_ready === exp_rdy) else begin
      n_fail++;
      $error("FAIL %s/enq_ready: observed %0b expected %0b", tag, bus.enq_ready, exp_rdy);
    end
    n_assert++;
    assert (bus.free_valid_by_bank === exp_vld) else begin
      n_fail++;
      $error("FAIL %s/free_valid: observed %b expected %b", tag, bus.free_valid_by_bank, exp_vld);
    end
    n_assert++;
    assert (obs_up === exp_up) else begin
      n_fail++;
      $error("FAIL %s/upper_PR: observed %h expected %h", tag, obs_up, exp_up);
    end
    n_assert++;
    assert (bus.occupancy === exp_occ) else begin
      n_fail++;
      $error("FAIL %s/occupancy: observed %0d expected %0d", tag, bus.occupancy, exp_occ);
    end
  endtask

  task automatic set_enq(input logic vld, input logic [3:0] mask,
                         input PR_t p3, input PR_t p2, input PR_t p1, input PR_t p0);
    bus.enq_valid      = vld;
    bus.enq_free_mask  = mask;
    bus.enq_PR_by_lane = {p3, p2, p1, p0};
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    nrst     = 1'b0;
    bus.free_ready_by_bank = 4'hF;
    set_enq(1'b1, 4'hF, 7'h0F, 7'h0A, 7'h05, 7'h00);

    // Reset, including an enqueue offered while reset is held
    #1;
    check_state("reset", 1'b1, 4'b0000, 20'h0, 2'd0);
    cyc();
    cyc();
    check_state("reset_enq", 1'b1, 4'b0000, 20'h0, 2'd0);
    set_enq(1'b0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00);
    #2 nrst = 1'b1;
    cyc();
    check_state("post_reset", 1'b1, 4'b0000, 20'h0, 2'd0);

    // One PR per bank drains in a single cycle
    set_enq(1'b1, 4'hF, 7'h0F, 7'h0A, 7'h05, 7'h00);
    cyc();
    set_enq(1'b0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00);
    check_state("spread_issue", 1'b1, 4'b1111, up4(3, 2, 1, 0), 2'd1);
    cyc();
    check_state("spread_empty", 1'b1, 4'b0000, 20'h0, 2'd0);

    // Four bank-0 PRs serialize lowest lane first
    set_enq(1'b1, 4'hF, 7'h10, 7'h0C, 7'h08, 7'h04);
    cyc();
    set_enq(1'b0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00);
    check_state("coll_1", 1'b1, 4'b0001, up4(0, 0, 0, 1), 2'd1);
    cyc();
    check_state("coll_2", 1'b1, 4'b0001, up4(0, 0, 0, 2), 2'd1);
    cyc();
    check_state("coll_3", 1'b1, 4'b0001, up4(0, 0, 0, 3), 2'd1);
    cyc();
    check_state("coll_4", 1'b1, 4'b0001, up4(0, 0, 0, 4), 2'd1);
    cyc();
    check_state("coll_empty", 1'b1, 4'b0000, 20'h0, 2'd0);

    // Fill under backpressure, stall a third group, then drain
    bus.free_ready_by_bank = 4'h0;
    set_enq(1'b1, 4'hF, 7'h0F, 7'h0A, 7'h05, 7'h00);
    cyc();
    check_state("fill_1", 1'b1, 4'b1111, up4(3, 2, 1, 0), 2'd1);
    set_enq(1'b1, 4'hF, 7'h10, 7'h0C, 7'h08, 7'h04);
    cyc();
    check_state("fill_2", 1'b0, 4'b1111, up4(3, 2, 1, 0), 2'd2);
    set_enq(1'b1, 4'h1, 7'h00, 7'h00, 7'h00, 7'h01);
    cyc();
    check_state("stall", 1'b0, 4'b1111, up4(3, 2, 1, 0), 2'd2);
    bus.free_ready_by_bank = 4'hF;
    cyc();
    check_state("pop_space", 1'b1, 4'b0001, up4(0, 0, 0, 1), 2'd1);
    cyc();
    set_enq(1'b0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00);
    check_state("refill", 1'b0, 4'b0001, up4(0, 0, 0, 2), 2'd2);
    cyc();
    cyc();
    check_state("drain_b4", 1'b0, 4'b0001, up4(0, 0, 0, 4), 2'd2);
    cyc();
    check_state("drain_c", 1'b1, 4'b0010, 20'h0, 2'd1);
    cyc();
    check_state("drain_empty", 1'b1, 4'b0000, 20'h0, 2'd0);

    // All-zero mask is consumed without allocating
    set_enq(1'b1, 4'h0, 7'h0F, 7'h0A, 7'h05, 7'h00);
    cyc();
    set_enq(1'b0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00);
    check_state("zero_mask", 1'b1, 4'b0000, 20'h0, 2'd0);

    // Bank 2 stalled: other banks drain, bank 2 holds, then async reset mid-stall
    bus.free_ready_by_bank = 4'b1011;
    set_enq(1'b1, 4'hF, 7'h01, 7'h06, 7'h03, 7'h02);
    cyc();
    set_enq(1'b0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00);
    check_state("b2_first", 1'b1, 4'b1110, up4(0, 0, 0, 0), 2'd1);
    cyc();
    check_state("b2_hold_a", 1'b1, 4'b0100, up4(0, 0, 0, 0), 2'd1);
    cyc();
    check_state("b2_hold_b", 1'b1, 4'b0100, up4(0, 0, 0, 0), 2'd1);
    bus.free_ready_by_bank = 4'b1111;
    cyc();
    bus.free_ready_by_bank = 4'b1011;
    check_state("b2_next", 1'b1, 4'b0100, up4(0, 1, 0, 0), 2'd1);
    cyc();
    check_state("b2_next_hold", 1'b1, 4'b0100, up4(0, 1, 0, 0), 2'd1);
    #2 nrst = 1'b0;
    #1;
    check_state("async_reset", 1'b1, 4'b0000, 20'h0, 2'd0);
    #2 nrst = 1'b1;
    cyc();
    check_state("after_reset", 1'b1, 4'b0000, 20'h0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
